// File: rtl/bus_hs_pkg.sv
// Shared defaults and types for the valid/ready bus demonstration link.
package bus_hs_pkg;
  localparam int DATA_W_DEF = 3;
  localparam int CNT_W_DEF  = 8;

  typedef logic [DATA_W_DEF-1:0] data_t;
endpackage

// File: rtl/hs_master.sv
// Source stage: one-word register driving the bus, with combinational in_ready
// so a new word can load in the same cycle the current one transfers.
module hs_master
  import bus_hs_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_in,
  input  logic              valid_in,
  input  logic              bus_ready,
  output logic              in_ready,
  output logic              bus_valid,
  output logic [DATA_W-1:0] bus_data
);

  logic              bus_valid_d, bus_valid_q;
  logic [DATA_W-1:0] bus_data_d, bus_data_q;

  always_comb begin
    in_ready    = !bus_valid_q || bus_ready;
    bus_valid_d = bus_valid_q;
    bus_data_d  = bus_data_q;
    // Load takes priority so a transfer plus a new word keeps the bus full.
    if (valid_in && in_ready) begin
      bus_valid_d = 1'b1;
      bus_data_d  = data_in;
    end else if (bus_valid_q && bus_ready) begin
      bus_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus_valid_q <= 1'b0;
      bus_data_q  <= '0;
    end else begin
      bus_valid_q <= bus_valid_d;
      bus_data_q  <= bus_data_d;
    end
  end

  assign bus_valid = bus_valid_q;
  assign bus_data  = bus_data_q;

endmodule

// File: rtl/hs_slave.sv
// Sink stage: captures each transferred bus word, pulses data_out_vld and
// counts completed transfers (wrapping counter).
module hs_slave
  import bus_hs_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bus_valid,
  input  logic              bus_ready,
  input  logic [DATA_W-1:0] bus_data,
  output logic [DATA_W-1:0] data_out,
  output logic              data_out_vld,
  output logic [CNT_W-1:0]  xfer_cnt
);

  logic              xfer;
  logic [DATA_W-1:0] data_out_d, data_out_q;
  logic              data_out_vld_d, data_out_vld_q;
  logic [CNT_W-1:0]  xfer_cnt_d, xfer_cnt_q;

  always_comb begin
    xfer           = bus_valid && bus_ready;
    data_out_d     = data_out_q;
    data_out_vld_d = 1'b0;
    xfer_cnt_d     = xfer_cnt_q;
    if (xfer) begin
      data_out_d     = bus_data;
      data_out_vld_d = 1'b1;
      xfer_cnt_d     = xfer_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_out_q     <= '0;
      data_out_vld_q <= 1'b0;
      xfer_cnt_q     <= '0;
    end else begin
      data_out_q     <= data_out_d;
      data_out_vld_q <= data_out_vld_d;
      xfer_cnt_q     <= xfer_cnt_d;
    end
  end

  assign data_out     = data_out_q;
  assign data_out_vld = data_out_vld_q;
  assign xfer_cnt     = xfer_cnt_q;

endmodule

// File: rtl/bus_handshake_top.sv
// Valid/ready link: hs_master feeds hs_slave over an internal bus whose ready
// is the downstream ready_in; bus and sink signals are exposed for observation.
module bus_handshake_top
  import bus_hs_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic [DATA_W-1:0] data_in,
  input  logic              valid_in,
  input  logic              ready_in,
  output logic              in_ready,
  output logic              bus_valid,
  output logic [DATA_W-1:0] bus_data,
  output logic              bus_ready,
  output logic [DATA_W-1:0] data_out,
  output logic              data_out_vld,
  output logic [CNT_W-1:0]  xfer_cnt
);

  assign bus_ready = ready_in;

  hs_master #(.DATA_W(DATA_W)) u_master (
    .clk       (sys_clk),
    .rst       (sys_rst),
    .data_in   (data_in),
    .valid_in  (valid_in),
    .bus_ready (bus_ready),
    .in_ready  (in_ready),
    .bus_valid (bus_valid),
    .bus_data  (bus_data)
  );

  hs_slave #(.DATA_W(DATA_W), .CNT_W(CNT_W)) u_slave (
    .clk          (sys_clk),
    .rst          (sys_rst),
    .bus_valid    (bus_valid),
    .bus_ready    (bus_ready),
    .bus_data     (bus_data),
    .data_out     (data_out),
    .data_out_vld (data_out_vld),
    .xfer_cnt     (xfer_cnt)
  );

endmodule

// File: tb/tb_bus_handshake_top.sv
// Self-checking bench for bus_handshake_top: directed scenarios plus random
// traffic, all compared against a queue-based one-slot buffer model.
module tb_bus_handshake_top;
  import bus_hs_pkg::*;

  logic       sys_clk = 1'b0;
  logic       sys_rst = 1'b1;
  data_t      data_in = '0;
  logic       valid_in = 1'b0;
  logic       ready_in = 1'b0;
  logic       in_ready, bus_valid, bus_ready, data_out_vld;
  data_t      bus_data, data_out;
  logic [7:0] xfer_cnt;

  int checks = 0;
  int failures = 0;

  // Reference model: the link is a buffer holding at most one word.
  data_t mq[$];
  data_t m_bus_data, m_out;
  logic  m_vld, exp_in_ready;
  int    m_cnt;
  logic  obs_in_ready, obs_bus_ready;
  data_t seen[$];

  always #5 sys_clk = ~sys_clk;

  bus_handshake_top dut (
    .sys_clk      (sys_clk),
    .sys_rst      (sys_rst),
    .data_in      (data_in),
    .valid_in     (valid_in),
    .ready_in     (ready_in),
    .in_ready     (in_ready),
    .bus_valid    (bus_valid),
    .bus_data     (bus_data),
    .bus_ready    (bus_ready),
    .data_out     (data_out),
    .data_out_vld (data_out_vld),
    .xfer_cnt     (xfer_cnt)
  );

  function automatic void model_reset();
    mq.delete();
    m_bus_data = '0;
    m_out = '0;
    m_vld = 1'b0;
    m_cnt = 0;
  endfunction

  function automatic void model_step(input logic v, input data_t d, input logic r);
    logic xfer;
    exp_in_ready = (mq.size() == 0) || r;
    xfer = (mq.size() != 0) && r;
    if (xfer) begin
      m_out = mq.pop_front();
      m_cnt = (m_cnt + 1) % 256;
    end
    m_vld = xfer;
    if (v && exp_in_ready) begin
      mq.push_back(d);
      m_bus_data = d;
    end
  endfunction

  // Drive one cycle: inputs just after an edge, combinational sample mid-cycle,
  // registered outputs become observable 1ns after the next edge.
  task automatic cycle(input logic v, input data_t d, input logic r);
    valid_in = v;
    data_in  = d;
    ready_in = r;
    #2;
    obs_in_ready  = in_ready;
    obs_bus_ready = bus_ready;
    model_step(v, d, r);
    @(posedge sys_clk);
    #1;
    if (data_out_vld) seen.push_back(data_out);
  endtask

  task automatic test_reset();
    cycle(1'b1, 3'd2, 1'b1);
    cycle(1'b1, 3'd3, 1'b1);
    checks++;
    if (bus_valid !== 1'b1) begin
      failures++; $display("FAIL rst_precond bus_valid got=%0b exp=1", bus_valid);
    end
    #2;
    sys_rst = 1'b1;
    #1;
    model_reset();
    checks++;
    if ({bus_valid, bus_data, data_out, data_out_vld, xfer_cnt} !== '0) begin
      failures++;
      $display("FAIL rst_async bv=%0b bd=%0d do=%0d vld=%0b cnt=%0d exp all 0",
               bus_valid, bus_data, data_out, data_out_vld, xfer_cnt);
    end
    @(posedge sys_clk);
    #1;
    sys_rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 3'd5, 1'b1);
      checks++;
      if (bus_valid !== 1'b0 || data_out_vld !== 1'b0 || xfer_cnt !== 8'd0 || obs_in_ready !== 1'b1) begin
        failures++;
        $display("FAIL rst_idle bv=%0b vld=%0b cnt=%0d inr=%0b exp 0 0 0 1",
                 bus_valid, data_out_vld, xfer_cnt, obs_in_ready);
      end
    end
  endtask

  task automatic test_stream();
    data_t pat[5];
    pat = '{3'd2, 3'd3, 3'd3, 3'd1, 3'd2};
    seen.delete();
    for (int i = 0; i < 7; i++) begin
      if (i < 5) cycle(1'b1, pat[i], 1'b1);
      else cycle(1'b0, 3'd0, 1'b1);
      checks++;
      if (bus_valid !== (mq.size() != 0) || bus_data !== m_bus_data || data_out_vld !== m_vld ||
          data_out !== m_out || xfer_cnt !== m_cnt[7:0]) begin
        failures++;
        $display("FAIL stream cyc=%0d got bv=%0b bd=%0d vld=%0b do=%0d cnt=%0d exp bv=%0b bd=%0d vld=%0b do=%0d cnt=%0d",
                 i, bus_valid, bus_data, data_out_vld, data_out, xfer_cnt,
                 (mq.size() != 0), m_bus_data, m_vld, m_out, m_cnt[7:0]);
      end
      // Words 1..5 land on data_out after edges 2..6 of this sequence.
      checks++;
      if (data_out_vld !== (i >= 1 && i <= 5)) begin
        failures++; $display("FAIL stream_vld_timing cyc=%0d got=%0b", i, data_out_vld);
      end
    end
    checks++;
    if (seen.size() != 5 || seen[0] !== 3'd2 || seen[1] !== 3'd3 || seen[2] !== 3'd3 ||
        seen[3] !== 3'd1 || seen[4] !== 3'd2 || xfer_cnt !== 8'd5) begin
      failures++;
      $display("FAIL stream_seq n=%0d cnt=%0d exp n=5 seq 2,3,3,1,2 cnt=5", seen.size(), xfer_cnt);
    end
  endtask

  task automatic test_stall_drop();
    int cnt0;
    cnt0 = m_cnt;
    seen.delete();
    cycle(1'b1, 3'd3, 1'b0);
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 3'd1, 1'b0);
      checks++;
      if (bus_valid !== 1'b1 || bus_data !== 3'd3 || obs_in_ready !== 1'b0 ||
          data_out_vld !== 1'b0 || obs_bus_ready !== 1'b0) begin
        failures++;
        $display("FAIL stall cyc=%0d got bv=%0b bd=%0d inr=%0b vld=%0b br=%0b exp 1 3 0 0 0",
                 i, bus_valid, bus_data, obs_in_ready, data_out_vld, obs_bus_ready);
      end
    end
    cycle(1'b0, 3'd1, 1'b1);
    checks++;
    if (data_out !== 3'd3 || data_out_vld !== 1'b1 || xfer_cnt !== 8'((cnt0 + 1) % 256) ||
        bus_valid !== 1'b0 || obs_bus_ready !== 1'b1) begin
      failures++;
      $display("FAIL stall_release got do=%0d vld=%0b cnt=%0d bv=%0b exp do=3 vld=1 cnt=%0d bv=0",
               data_out, data_out_vld, xfer_cnt, bus_valid, (cnt0 + 1) % 256);
    end
    cycle(1'b0, 3'd1, 1'b1);
    checks++;
    if (seen.size() != 1 || data_out_vld !== 1'b0 || bus_data !== 3'd3) begin
      failures++;
      $display("FAIL drop words_out=%0d vld=%0b bd=%0d exp 1 0 3", seen.size(), data_out_vld, bus_data);
    end
  endtask

  task automatic test_drain();
    cycle(1'b1, 3'd6, 1'b1);
    cycle(1'b0, 3'd0, 1'b1);
    checks++;
    if (bus_valid !== 1'b0 || data_out !== 3'd6 || data_out_vld !== 1'b1) begin
      failures++;
      $display("FAIL drain got bv=%0b do=%0d vld=%0b exp 0 6 1", bus_valid, data_out, data_out_vld);
    end
    cycle(1'b0, 3'd0, 1'b1);
    checks++;
    if (bus_valid !== 1'b0 || data_out !== 3'd6 || data_out_vld !== 1'b0 || bus_data !== 3'd6) begin
      failures++;
      $display("FAIL drain_hold got bv=%0b do=%0d vld=%0b bd=%0d exp 0 6 0 6",
               bus_valid, data_out, data_out_vld, bus_data);
    end
  endtask

  task automatic test_random();
    logic v, r, bv_prev;
    data_t d, bd_prev;
    for (int i = 0; i < 300; i++) begin
      bv_prev = bus_valid;
      bd_prev = bus_data;
      v = 1'($urandom_range(0, 3) != 0);
      r = 1'($urandom_range(0, 2) != 0);
      d = data_t'($urandom);
      cycle(v, d, r);
      checks++;
      if (obs_in_ready !== exp_in_ready || bus_valid !== (mq.size() != 0) || bus_data !== m_bus_data ||
          data_out_vld !== m_vld || data_out !== m_out || xfer_cnt !== m_cnt[7:0]) begin
        failures++;
        $display("FAIL random cyc=%0d got inr=%0b bv=%0b bd=%0d vld=%0b do=%0d cnt=%0d exp inr=%0b bv=%0b bd=%0d vld=%0b do=%0d cnt=%0d",
                 i, obs_in_ready, bus_valid, bus_data, data_out_vld, data_out, xfer_cnt,
                 exp_in_ready, (mq.size() != 0), m_bus_data, m_vld, m_out, m_cnt[7:0]);
      end
      checks++;
      if (bv_prev && !r && (bus_valid !== 1'b1 || bus_data !== bd_prev)) begin
        failures++;
        $display("FAIL random_stall_stable cyc=%0d bv=%0b bd=%0d exp bv=1 bd=%0d", i, bus_valid, bus_data, bd_prev);
      end
    end
  endtask

  task automatic test_wrap();
    @(negedge sys_clk);
    sys_rst = 1'b1;
    model_reset();
    @(posedge sys_clk);
    #1;
    sys_rst = 1'b0;
    for (int i = 0; i < 256; i++) begin
      cycle(1'b1, data_t'(i), 1'b1);
      checks++;
      if (xfer_cnt !== m_cnt[7:0] || data_out !== m_out) begin
        failures++;
        $display("FAIL wrap_run cyc=%0d cnt=%0d do=%0d exp cnt=%0d do=%0d", i, xfer_cnt, data_out, m_cnt[7:0], m_out);
      end
    end
    cycle(1'b0, 3'd0, 1'b1);
    checks++;
    if (xfer_cnt !== 8'd0 || data_out_vld !== 1'b1 || data_out !== 3'd7) begin
      failures++;
      $display("FAIL wrap_final cnt=%0d vld=%0b do=%0d exp cnt=0 vld=1 do=7", xfer_cnt, data_out_vld, data_out);
    end
  endtask

  initial begin
    model_reset();
    @(posedge sys_clk);
    #1;
    checks++;
    if ({bus_valid, bus_data, data_out, data_out_vld, xfer_cnt} !== '0) begin
      failures++; $display("FAIL por_state got nonzero outputs during reset");
    end
    sys_rst = 1'b0;
    test_reset();
    test_stream();
    test_stall_drop();
    test_drain();
    test_random();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout sim time exceeded");
    $fatal(1);
  end

endmodule

// File: doc/bus_handshake_top.md
Name: bus_handshake_top

Overview:
- Demonstration valid/ready bus link with one source (master) stage and one sink (slave) stage, joined by an internal valid/ready bus.
- The master registers upstream data words and drives them onto the bus. The slave accepts a bus word when its downstream side is ready and registers it as output.
- Exposes bus and sink observation outputs for verification. Stand-alone top-level block.

Parameters:
- DATA_W, 3, width of data_in, bus data and data_out.
- CNT_W, 8, width of the accepted-transfer counter.

Ports:
- sys_clk  in  1  single clock; all flops on the rising edge.
- sys_rst  in  1  asynchronous, active-high reset.
- data_in  in  DATA_W  upstream data word.
- valid_in  in  1  upstream data word valid.
- ready_in  in  1  downstream sink ready; drives the bus ready.
- in_ready  out  1  master can accept data_in this cycle.
- bus_valid  out  1  master-to-slave bus valid (registered).
- bus_data  out  DATA_W  master-to-slave bus data (registered).
- bus_ready  out  1  slave-to-master bus ready; equals ready_in, combinational.
- data_out  out  DATA_W  last word accepted by the slave (registered).
- data_out_vld  out  1  one-cycle pulse per accepted word.
- xfer_cnt  out  CNT_W  number of completed bus transfers.

Behaviour:
- Reset, asynchronous and active-high: bus_valid=0, bus_data=0, data_out=0, data_out_vld=0, xfer_cnt=0. Takes effect immediately and overrides any in-flight word; the word is discarded.
- Bus transfer occurs in a cycle where bus_valid && bus_ready.
- in_ready = !bus_valid || bus_ready. This is combinational and needs no upstream flop.
- Master load, when valid_in && in_ready: bus_valid<=1, bus_data<=data_in.
- Master drain, when the transfer completes and !valid_in: bus_valid<=0; bus_data holds its value.
- Master stall, when bus_valid && !bus_ready: bus_valid and bus_data hold stable. They must not change until the transfer completes.
- If valid_in is high while in_ready is low, that word is not captured (dropped). The upstream side is responsible for honouring in_ready.
- Slave capture, on transfer: data_out<=bus_data, data_out_vld<=1, and xfer_cnt increments by 1, wrapping modulo 2^CNT_W.
- When no transfer occurs: data_out_vld<=0 and data_out holds its value.
- Latency: a word accepted at edge N appears on the bus after N. With ready_in high, it appears on data_out after edge N+1, i.e. 2 cycles input to output.
- Throughput: with valid_in and ready_in both held high, one word per cycle, no bubbles. Simultaneous transfer and load in one cycle is required.
- Back-pressure: with ready_in low, at most one word is buffered; in_ready drops while bus_valid=1.
- bus_valid must never fall without a transfer, except by reset.

Decomposition:
- Package bus_hs_pkg: DATA_W, CNT_W defaults and a data_t typedef.
- Sub-module hs_master holds the source register and the in_ready logic.
- Sub-module hs_slave holds the capture register, data_out_vld and xfer_cnt.
- bus_handshake_top only wires the two together.

Test Plan:
- Reset asserted mid-stream with bus_valid=1 -> all outputs 0 immediately (asynchronous); after release, idle until valid_in.
- Streaming: valid_in=ready_in=1 for 5 cycles, data 2,3,3,1,2 -> bus_data follows 1 cycle later; data_out 2,3,3,1,2 on consecutive cycles 2 cycles after input; data_out_vld high 5 cycles; xfer_cnt=5.
- Stall: load 3 with ready_in=0 for 4 cycles -> bus_valid=1, bus_data=3 stable, in_ready=0, no data_out_vld; raise ready_in -> data_out=3, one pulse, xfer_cnt+1.
- Drop: valid_in=1 with data 1 while stalled -> word 1 never appears on the bus or data_out.
- Drain: valid_in falls while ready_in=1 -> bus_valid=0 the next cycle, data_out holds its last value, data_out_vld=0.
- Counter wrap: 256 transfers from 0 -> xfer_cnt returns to 0.
